// File: rtl/fft32_frame_scheduler.sv
// Frame scheduler for the fft32 HLS kernel. It runs a programmed number of invocations and gates
// the input stream to FRAME_LEN beats per frame. A progress watchdog turns stalls into errors.
module fft32_frame_scheduler #(
   parameter int unsigned FRAME_LEN = 32,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   input  logic             cfg_start,
   input  logic             cfg_abort,
   input  logic [CNT_W-1:0] cfg_num_frames,
   output logic             ap_start,
   input  logic             ap_ready,
   input  logic             ap_done,
   input  logic             src_tvalid,
   output logic             src_tready,
   output logic             krn_in_tvalid,
   input  logic             krn_in_tready,
   input  logic             krn_out_tvalid,
   input  logic             krn_out_tready,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] frames_done
);

   localparam int unsigned BW = $clog2(FRAME_LEN + 2);
   localparam int unsigned WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [BW-1:0] LenB  = BW'(FRAME_LEN);
   localparam logic [BW-1:0] SatB  = BW'(FRAME_LEN + 1);
   localparam logic [WW-1:0] WdMax = WW'(TIMEOUT - 1);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StStart = 3'd1;
   localparam logic [2:0] StFeed  = 3'd2;
   localparam logic [2:0] StWait  = 3'd3;
   localparam logic [2:0] StDone  = 3'd4;
   localparam logic [2:0] StErr   = 3'd5;

   logic [2:0]       state_q, state_d;
   logic [BW-1:0]    in_cnt_q, in_cnt_d;
   logic [BW-1:0]    out_cnt_q, out_cnt_d;
   logic [CNT_W-1:0] num_q, num_d;
   logic [CNT_W-1:0] frames_q, frames_d, frames_inc;
   logic [WW-1:0]    wd_q, wd_d;
   logic             err_q, err_d;
   logic [1:0]       code_q, code_d;
   logic             zdone_q, zdone_d;
   logic             in_beat, out_beat, gate_open, progress;

   assign busy          = (state_q == StStart) | (state_q == StFeed) | (state_q == StWait);
   assign gate_open     = (state_q == StFeed) & (in_cnt_q < LenB);
   assign krn_in_tvalid = src_tvalid & gate_open;
   assign src_tready    = krn_in_tready & gate_open;
   assign in_beat       = krn_in_tvalid & krn_in_tready;
   assign out_beat      = krn_out_tvalid & krn_out_tready;
   assign progress      = in_beat | out_beat | ap_done | ((state_q == StStart) & ap_ready);
   assign frames_inc    = frames_q + CNT_W'(1);

   assign ap_start    = (state_q == StStart);
   assign done        = (state_q == StDone) | zdone_q;
   assign err         = err_q;
   assign err_code    = code_q;
   assign frames_done = frames_q;

   always_comb begin
      state_d   = state_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      num_d     = num_q;
      frames_d  = frames_q;
      err_d     = err_q;
      code_d    = code_q;
      zdone_d   = 1'b0;

      // out_cnt_d already includes a beat landing in the same cycle as ap_done
      if (busy && out_beat && (out_cnt_q != SatB)) out_cnt_d = out_cnt_q + BW'(1);

      case (state_q)
         StIdle, StErr: begin
            if (cfg_start) begin
               if (cfg_num_frames != '0) begin
                  state_d  = StStart;
                  num_d    = cfg_num_frames;
                  frames_d = '0;
                  err_d    = 1'b0;
                  code_d   = 2'd0;
               end else begin
                  state_d = StIdle;
                  zdone_d = 1'b1;
               end
            end
         end
         StStart: if (ap_ready) state_d = StFeed;
         StFeed: begin
            if (ap_done) begin
               state_d = StErr;
               err_d   = 1'b1;
               code_d  = 2'd2;
            end else if (in_beat) begin
               in_cnt_d = in_cnt_q + BW'(1);
               if (in_cnt_d == LenB) state_d = StWait;
            end
         end
         StWait: begin
            if (ap_done) begin
               if (out_cnt_d != LenB) begin
                  state_d = StErr;
                  err_d   = 1'b1;
                  code_d  = 2'd3;
               end else begin
                  frames_d = frames_inc;
                  state_d  = (frames_inc == num_q) ? StDone : StStart;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      if (busy && !progress && (state_d == state_q) && (wd_q == WdMax)) begin
         state_d = StErr;
         err_d   = 1'b1;
         code_d  = (state_q == StFeed) ? 2'd1 : 2'd2;
      end

      // Abort wins over everything, including a same-cycle completion or error
      if (cfg_abort) begin
         state_d  = StIdle;
         zdone_d  = 1'b0;
         num_d    = num_q;
         frames_d = frames_q;
         err_d    = err_q;
         code_d   = code_q;
      end

      if ((state_d == StStart) && (state_q != StStart)) begin
         in_cnt_d  = '0;
         out_cnt_d = '0;
      end

      wd_d = (!busy || progress || (state_d != state_q)) ? '0 : wd_q + WW'(1);
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q   <= StIdle;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         num_q     <= '0;
         frames_q  <= '0;
         wd_q      <= '0;
         err_q     <= 1'b0;
         code_q    <= 2'd0;
         zdone_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         num_q     <= num_d;
         frames_q  <= frames_d;
         wd_q      <= wd_d;
         err_q     <= err_d;
         code_q    <= code_d;
         zdone_q   <= zdone_d;
      end
   end

endmodule
